systolic_result_reader: RTL and testbench

Drains the systolic array's result SRAM after a computation finishes. One rd_start pulse (normally wired from tpu_done) streams every result row, data_set 0 then 1, matrix_index 0..ARRAY_SIZE-1 within each set. Rows go out over a valid/ready interface. The block hides the SRAM's 1-cycle read latency behind a 2-entry output buffer and sits between the result SRAM read port and the host/DMA side.

---
 rtl/systolic_result_reader_pkg.sv | 31 +++
 rtl/systolic_result_reader_if.sv | 22 ++
 rtl/systolic_result_reader_fifo.sv | 58 +++++
 rtl/systolic_result_reader.sv | 122 ++++++++++++
 tb/tb_systolic_result_reader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_result_reader_pkg.sv
// Shared sizes, row/tag types and reader FSM states for the result-SRAM reader.
package systolic_pkg;

  localparam int ARRAY_SIZE = 16;
  localparam int NUM_SETS   = 2;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int ADDR_W     = $clog2(NUM_SETS * ARRAY_SIZE);
  localparam int IDX_W      = $clog2(ARRAY_SIZE);
  localparam int SET_W      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int ROW_W      = ARRAY_SIZE * OUT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;

  typedef struct packed {
    logic             last;
    logic [SET_W-1:0] set;
    logic [IDX_W-1:0] index;
  } row_tag_t;

  typedef struct packed {
    row_tag_t         tag;
    logic [ROW_W-1:0] data;
  } row_t;

endpackage

// File: rtl/systolic_result_reader_if.sv
// Valid/ready result-row stream; master is the reader, slave is the host/DMA side.
interface systolic_result_reader_if;
  import systolic_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_data;
  logic [SET_W-1:0] out_set;
  logic [IDX_W-1:0] out_index;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_set, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_set, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/systolic_result_reader_fifo.sv
// Two-entry synchronous FIFO of converted rows with tags; head is visible combinationally.
module systolic_out_fifo
  import systolic_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       push_i,
  input  row_t       push_dat_i,
  input  logic       pop_i,
  output row_t       pop_dat_o,
  output logic [1:0] count_o,
  output logic       empty_o,
  output logic       full_o
);

  row_t       mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == 2'd0);
  assign full_o    = (count_q == 2'd2);

endmodule

// File: rtl/systolic_result_reader.sv
// Drains all result-SRAM rows (set 0 then 1) over valid/ready after rd_start, one row per cycle.
// Build option RESULT_SAT_EN: lanes saturate to signed OUT_W instead of truncating.
module systolic_result_reader
  import systolic_pkg::*;
(
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        rd_start,
  output logic                        busy,
  output logic                        sram_rd_en,
  output logic [ADDR_W-1:0]           sram_rd_addr,
  input  logic [ARRAY_SIZE*ACC_W-1:0] sram_rd_data,
  systolic_result_reader_if.master    out_if,
  output logic                        rd_done
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_READ  = 2'(ST_READ);
  localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SETS * ARRAY_SIZE - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              infl_q, infl_d;
  row_tag_t          infl_tag_q, infl_tag_d;

  row_t              fifo_in, fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_empty, fifo_full_unused;
  logic              pop;
  logic [2:0]        occ_after_pop;
  logic [ROW_W-1:0]  conv_row;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [ACC_W-1:0] lane;
    logic [OUT_W-1:0] lane_out;
    assign lane = sram_rd_data[i*ACC_W +: ACC_W];
`ifdef RESULT_SAT_EN
    // In range exactly when every bit from the OUT_W sign bit upward matches.
    logic [ACC_W-OUT_W:0] lane_hi;
    assign lane_hi  = lane[ACC_W-1:OUT_W-1];
    assign lane_out = (&lane_hi || ~|lane_hi) ? lane[OUT_W-1:0] :
                      lane[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                      {1'b0, {(OUT_W-1){1'b1}}};
`else
    logic lane_hi_unused;
    assign lane_hi_unused = ^lane[ACC_W-1:OUT_W];
    assign lane_out       = lane[OUT_W-1:0];
`endif
    assign conv_row[i*OUT_W +: OUT_W] = lane_out;
  end

  // Credit counts the slot freed by this cycle's pop so a steady stream runs at one row per cycle.
  assign pop           = !fifo_empty && out_if.out_ready;
  assign occ_after_pop = 3'(fifo_count) + 3'(infl_q) - 3'(pop);
  assign sram_rd_en    = (state_q == S_READ) && (occ_after_pop < 3'd2);
  assign sram_rd_addr  = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign rd_done       = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    infl_d     = sram_rd_en;
    infl_tag_d = infl_tag_q;
    if (sram_rd_en) begin
      addr_d           = addr_q + ADDR_W'(1);
      infl_tag_d.last  = (addr_q == LAST_ADDR);
      infl_tag_d.set   = addr_q[IDX_W +: SET_W];
      infl_tag_d.index = addr_q[IDX_W-1:0];
    end
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ:  if (sram_rd_en && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN: if (occ_after_pop == 3'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      infl_q     <= 1'b0;
      infl_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      infl_q     <= infl_d;
      infl_tag_q <= infl_tag_d;
    end
  end

  assign fifo_in.tag  = infl_tag_q;
  assign fifo_in.data = conv_row;

  systolic_out_fifo u_fifo (
    .clk        (clk),
    .srst       (srst),
    .push_i     (infl_q),
    .push_dat_i (fifo_in),
    .pop_i      (pop),
    .pop_dat_o  (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full_unused)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_head.data;
  assign out_if.out_set   = fifo_head.tag.set;
  assign out_if.out_index = fifo_head.tag.index;
  assign out_if.out_last  = fifo_head.tag.last;

endmodule

// File: tb/tb_systolic_result_reader.sv
// Self-checking bench for systolic_result_reader: SRAM model, stream scoreboard, table and random runs.
module tb_systolic_result_reader;
  import systolic_pkg::*;

  localparam int CW    = ROW_W + 8;
  localparam int NW    = NUM_SETS * ARRAY_SIZE;
  localparam int LIMIT = 1000;

  logic clk = 1'b0;
  logic srst, rd_start, busy, sram_rd_en, rd_done;
  logic [ADDR_W-1:0]           sram_rd_addr;
  logic [ARRAY_SIZE*ACC_W-1:0] sram_rd_data;
  logic [ARRAY_SIZE*ACC_W-1:0] mem [NW];

  systolic_result_reader_if rif();

  systolic_result_reader dut (
    .clk          (clk),
    .srst         (srst),
    .rd_start     (rd_start),
    .busy         (busy),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .out_if       (rif),
    .rd_done      (rd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROW_W-1:0] data;
    logic [SET_W-1:0] set;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  typedef struct {
    logic [ACC_W-1:0] lane;
    logic [OUT_W-1:0] exp_trunc;
    logic [OUT_W-1:0] exp_sat;
    string            name;
  } vec_t;

  exp_t             exp_q[$];
  vec_t             tbl[8];
  logic [ROW_W-1:0] cap[$];

  int checks = 0, errors = 0, cyc = 0, s_cyc = 0;
  int issued, accepted, got_words, done_count, first_valid, last_hs, done_cyc, first_addr;
  logic             mon_hs;
  logic             stall_prev = 1'b0;
  logic [CW-1:0]    prev_pl;
  exp_t             mon_e;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] payload();
    return CW'({rif.out_last, rif.out_set, rif.out_index, rif.out_data});
  endfunction

  // Reference lane conversion from the arithmetic definition.
  function automatic logic [OUT_W-1:0] ref_lane(input logic [ACC_W-1:0] v);
`ifdef RESULT_SAT_EN
    longint sv, hi, lo;
    sv = longint'($signed(v));
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    if (sv > hi) sv = hi;
    else if (sv < lo) sv = lo;
    return OUT_W'(sv);
`else
    return OUT_W'(longint'(v) % (longint'(1) << OUT_W));
`endif
  endfunction

  function automatic logic [OUT_W-1:0] tbl_exp(input int i);
`ifdef RESULT_SAT_EN
    return tbl[i].exp_sat;
`else
    return tbl[i].exp_trunc;
`endif
  endfunction

  function automatic void build_exp(input bit use_tbl);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < ARRAY_SIZE; j++)
        e.data[j*OUT_W +: OUT_W] = use_tbl ? tbl_exp((k + j) % 8) : ref_lane(mem[k][j*ACC_W +: ACC_W]);
      e.set  = SET_W'(k / ARRAY_SIZE);
      e.idx  = IDX_W'(k % ARRAY_SIZE);
      e.last = (k == NW - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic set_vec(input int i, input logic [ACC_W-1:0] lane, input logic [OUT_W-1:0] t,
                         input logic [OUT_W-1:0] s, input string name);
    tbl[i].lane = lane; tbl[i].exp_trunc = t; tbl[i].exp_sat = s; tbl[i].name = name;
  endtask

  task automatic fill_random();
    logic [ACC_W-1:0] v;
    for (int k = 0; k < NW; k++)
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        v = ACC_W'($urandom) >> $urandom_range(0, 24);
        if ($urandom_range(0, 1) == 1) v = -v;
        mem[k][j*ACC_W +: ACC_W] = v;
      end
  endtask

  // SRAM model: data one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
    else for (int j = 0; j < ARRAY_SIZE; j++) sram_rd_data[j*ACC_W +: ACC_W] <= ACC_W'($urandom);
  end

  always @(negedge clk) begin
    mon_hs = rif.out_valid && rif.out_ready;
    if (sram_rd_en) begin
      if (issued == 0) first_addr = int'(sram_rd_addr);
      chk("read_credit", CW'((issued - accepted - int'(mon_hs)) < 2), 1);
      issued++;
    end
    if (stall_prev) begin
      chk("stall_valid", rif.out_valid, 1);
      chk("stall_payload", payload(), prev_pl);
    end
    if (mon_hs) begin
      chk("queue_nonempty", CW'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("word_data", rif.out_data, mon_e.data);
        chk("word_set", rif.out_set, mon_e.set);
        chk("word_index", rif.out_index, mon_e.idx);
        chk("word_last", rif.out_last, mon_e.last);
      end
      cap.push_back(rif.out_data);
      accepted++;
      got_words++;
      last_hs = cyc;
    end
    if (rif.out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (rd_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    stall_prev = rif.out_valid && !rif.out_ready;
    prev_pl    = payload();
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_en"}, sram_rd_en, 0);
    chk({tag, "_rd_addr"}, sram_rd_addr, 0);
    chk({tag, "_valid"}, rif.out_valid, 0);
    chk({tag, "_payload"}, payload(), 0);
    chk({tag, "_rd_done"}, rd_done, 0);
  endtask

  // mode: 0 ready high, 1 ready 1,0,0,1, 2 random ready, 3 ready low for 20 cycles.
  task automatic run(input int mode, input int abort_at, input bit pulse_mid);
    int k;
    issued = 0; accepted = 0; got_words = 0; done_count = 0;
    first_valid = -1; last_hs = -1; done_cyc = -1; first_addr = -1;
    cap.delete();
    @(posedge clk); #1;
    rif.out_ready = (mode != 3);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    s_cyc = cyc;
    chk("busy_after_start", busy, 1);
    k = 0;
    while (done_count == 0 && k < LIMIT) begin
      if (mode == 3 && k == 20) begin
        chk("held_reads", issued, 2);
        chk("held_valid", rif.out_valid, 1);
        chk("held_words", got_words, 0);
      end
      case (mode)
        0:       rif.out_ready = 1'b1;
        1:       rif.out_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       rif.out_ready = 1'($urandom_range(0, 1));
        default: rif.out_ready = (k >= 20);
      endcase
      rd_start = pulse_mid && (k == 5);
      if (abort_at >= 0 && got_words >= abort_at) break;
      @(posedge clk); #1;
      k++;
    end
    rd_start = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_reached", got_words, abort_at);
      srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      chk_idle_outputs("abort");
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", done_count, 0);
      chk("abort_idle", busy, 0);
    end else begin
      chk("run_in_time", CW'(k < LIMIT), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("word_count", got_words, NW);
      chk("words_left", exp_q.size(), 0);
      chk("done_once", done_count, 1);
      chk("done_after_last", done_cyc - last_hs, 1);
      chk("first_addr", first_addr, 0);
      chk("idle_after", busy, 0);
    end
    rif.out_ready = 1'b1;
  endtask

  initial begin
    logic [OUT_W-1:0] want;
    set_vec(0, 32'h0001_2345, 16'h2345, 16'h7FFF, "pos_ovf");
    set_vec(1, 32'hFFFF_8000, 16'h8000, 16'h8000, "neg_min");
    set_vec(2, 32'h0000_7FFF, 16'h7FFF, 16'h7FFF, "pos_max");
    set_vec(3, 32'h0000_8000, 16'h8000, 16'h7FFF, "pos_edge");
    set_vec(4, 32'hFFFF_7FFF, 16'h7FFF, 16'h8000, "neg_edge");
    set_vec(5, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, "minus1");
    set_vec(6, 32'h8000_0000, 16'h0000, 16'h8000, "acc_min");
    set_vec(7, 32'h0000_0000, 16'h0000, 16'h0000, "zero");

    srst = 1'b1; rd_start = 1'b0; rif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    srst = 1'b0;
    repeat (2) @(posedge clk);

    // Row k carries lane value k; full-rate stream with latency checks.
    for (int k = 0; k < NW; k++)
      for (int j = 0; j < ARRAY_SIZE; j++) mem[k][j*ACC_W +: ACC_W] = ACC_W'(k);
    build_exp(1'b0);
    run(0, -1, 1'b0);
    chk("first_valid_lat", first_valid - s_cyc, 2);
    chk("last_hs_lat", last_hs - s_cyc, NW + 1);

    fill_random(); build_exp(1'b0); run(1, -1, 1'b0);
    fill_random(); build_exp(1'b0); run(3, -1, 1'b0);

    // Conversion table: word k lane j holds table entry (k+j)%8.
    for (int k = 0; k < NW; k++)
      for (int j = 0; j < ARRAY_SIZE; j++) mem[k][j*ACC_W +: ACC_W] = tbl[(k + j) % 8].lane;
    build_exp(1'b1);
    run(0, -1, 1'b0);
    chk("table_words", cap.size(), NW);
    if (cap.size() > 0)
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        want = tbl_exp(i % 8);
        chk({"lane_", tbl[i % 8].name}, cap[0][i*OUT_W +: OUT_W], want);
      end

    fill_random(); build_exp(1'b0); run(0, 10, 1'b0);
    fill_random(); build_exp(1'b0); run(0, -1, 1'b0);
    fill_random(); build_exp(1'b0); run(0, -1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fill_random(); build_exp(1'b0); run(2, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
